// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, next-PC selection, IMEM handshake
// and redirect latching with wrong-path squash toward the IF/ID register.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        HOLD,
    input  logic        MEM_BUSYWAIT,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    output logic [31:0] PC_IF,
    output logic [31:0] INSTRUCTION_IF,
    output logic        REDIRECT_PENDING,
    output logic [31:0] FETCH_COUNT
);

    typedef enum logic {BOOT, FETCH} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] pend_target, pend_target_nxt;
    logic [31:0] fetch_count, fetch_count_nxt;
    logic [31:0] branch_addr;
    logic        in_fetch;
    logic        adv;
    logic        instr_ok;

    assign branch_addr = BRANCH_TARGET & 32'hFFFF_FFFC;
    assign in_fetch    = (state == FETCH);
    assign adv         = in_fetch & ~IMEM_BUSYWAIT & ~MEM_BUSYWAIT & ~HOLD;
    // A word is only real if no redirect is in flight or pending.
    assign instr_ok    = in_fetch & ~IMEM_BUSYWAIT & ~pend_valid & ~BRANCH_TAKEN;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
            fetch_count <= fetch_count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
        fetch_count_nxt = fetch_count;
        IMEM_READ       = 1'b0;
        unique case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                IMEM_READ = 1'b1;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
        if (adv) begin
            pend_valid_nxt = 1'b0;
            if (BRANCH_TAKEN) begin
                pc_nxt = branch_addr;
            end else if (pend_valid) begin
                pc_nxt = pend_target;
            end else begin
                pc_nxt = pc + 32'(PC_INC);
            end
            if (instr_ok) begin
                fetch_count_nxt = fetch_count + 32'd1;
            end
        end else if (BRANCH_TAKEN) begin
            // Latest redirect wins while stalled.
            pend_valid_nxt  = 1'b1;
            pend_target_nxt = branch_addr;
        end
    end

    assign IMEM_ADDRESS     = pc;
    assign PC_IF            = pc;
    assign REDIRECT_PENDING = pend_valid;
    assign FETCH_COUNT      = fetch_count;
    assign INSTRUCTION_IF   = instr_ok ? IMEM_READDATA : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_if_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic        HOLD;
    logic        MEM_BUSYWAIT;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] PC_IF;
    logic [31:0] INSTRUCTION_IF;
    logic        REDIRECT_PENDING;
    logic [31:0] FETCH_COUNT;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        rd;
        logic        pend;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(4)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .HOLD(HOLD),
        .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .BRANCH_TAKEN(BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET),
        .IMEM_READDATA(IMEM_READDATA),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .IMEM_READ(IMEM_READ),
        .IMEM_ADDRESS(IMEM_ADDRESS),
        .PC_IF(PC_IF),
        .INSTRUCTION_IF(INSTRUCTION_IF),
        .REDIRECT_PENDING(REDIRECT_PENDING),
        .FETCH_COUNT(FETCH_COUNT)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign IMEM_READDATA = mem(IMEM_ADDRESS);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".addr"}, IMEM_ADDRESS, e.addr);
            chk({e.name, ".pc_if"}, PC_IF, e.addr);
            chk({e.name, ".instr"}, INSTRUCTION_IF, e.instr);
            chk({e.name, ".read"}, {31'd0, IMEM_READ}, {31'd0, e.rd});
            chk({e.name, ".pend"}, {31'd0, REDIRECT_PENDING}, {31'd0, e.pend});
            chk({e.name, ".count"}, FETCH_COUNT, e.cnt);
        end
    end

    // Queue the expectation for the current cycle, then move to the next one.
    task automatic step(input string nm, input logic [31:0] a,
                        input logic [31:0] ins, input logic rd,
                        input logic pd, input logic [31:0] c);
        exp_t e;
        e.name  = nm;
        e.addr  = a;
        e.instr = ins;
        e.rd    = rd;
        e.pend  = pd;
        e.cnt   = c;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET         = 1'b1;
        HOLD          = 1'b0;
        MEM_BUSYWAIT  = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = 32'd0;
        IMEM_BUSYWAIT = 1'b0;
        @(posedge CLK);
        #1;
        step("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        RESET = 1'b0;
        step("boot", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        step("f0", 32'h0, mem(32'h0), 1'b1, 1'b0, 32'd0);
        step("f4", 32'h4, mem(32'h4), 1'b1, 1'b0, 32'd1);

        IMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 5; i++)
            step("miss8", 32'h8, 32'h0, 1'b1, 1'b0, 32'd2);
        IMEM_BUSYWAIT = 1'b0;
        step("hit8", 32'h8, mem(32'h8), 1'b1, 1'b0, 32'd2);
        step("f12", 32'hC, mem(32'hC), 1'b1, 1'b0, 32'd3);
        step("f16", 32'h10, mem(32'h10), 1'b1, 1'b0, 32'd4);

        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h103;
        step("br20", 32'h14, 32'h0, 1'b1, 1'b0, 32'd5);
        BRANCH_TAKEN  = 1'b0;
        step("f100", 32'h100, mem(32'h100), 1'b1, 1'b0, 32'd5);

        HOLD          = 1'b1;
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h40;
        step("hold_br", 32'h104, 32'h0, 1'b1, 1'b0, 32'd6);
        BRANCH_TAKEN  = 1'b0;
        step("hold2", 32'h104, 32'h0, 1'b1, 1'b1, 32'd6);
        step("hold3", 32'h104, 32'h0, 1'b1, 1'b1, 32'd6);
        HOLD = 1'b0;
        step("apply40", 32'h104, 32'h0, 1'b1, 1'b1, 32'd6);
        step("f40", 32'h40, mem(32'h40), 1'b1, 1'b0, 32'd6);

        MEM_BUSYWAIT  = 1'b1;
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h80;
        step("mb_br1", 32'h44, 32'h0, 1'b1, 1'b0, 32'd7);
        BRANCH_TAKEN  = 1'b0;
        step("mb_a", 32'h44, 32'h0, 1'b1, 1'b1, 32'd7);
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'hC2;
        step("mb_br2", 32'h44, 32'h0, 1'b1, 1'b1, 32'd7);
        BRANCH_TAKEN  = 1'b0;
        step("mb_b", 32'h44, 32'h0, 1'b1, 1'b1, 32'd7);
        MEM_BUSYWAIT = 1'b0;
        step("mb_apply", 32'h44, 32'h0, 1'b1, 1'b1, 32'd7);
        step("fC0", 32'hC0, mem(32'hC0), 1'b1, 1'b0, 32'd7);

        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFF;
        step("br_top", 32'hC4, 32'h0, 1'b1, 1'b0, 32'd8);
        BRANCH_TAKEN  = 1'b0;
        step("ftop", 32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1'b1, 1'b0, 32'd8);
        step("wrap0", 32'h0, mem(32'h0), 1'b1, 1'b0, 32'd9);

        IMEM_BUSYWAIT = 1'b1;
        step("miss4", 32'h4, 32'h0, 1'b1, 1'b0, 32'd10);
        RESET = 1'b1;
        step("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        RESET         = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        step("boot2", 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        step("r_f0", 32'h0, mem(32'h0), 1'b1, 1'b0, 32'd0);
        step("r_f4", 32'h4, mem(32'h4), 1'b1, 1'b0, 32'd1);

        for (int i = 0; i < 5 && sb.size() > 0; i++)
            @(posedge CLK);
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
